// File: rtl/neuron_config_loader_if.sv
// Host word stream into the neuron config loader: plain valid/ready handshake.
// The loader is the slave; host_ready is registered inside it.
interface neuron_config_loader_if #(
   parameter int FP_DATA_WIDTH = 16
);
   logic [FP_DATA_WIDTH-1:0] host_data;
   logic                     host_valid;
   logic                     host_ready;

   modport master (output host_data, output host_valid, input host_ready);
   modport slave  (input host_data, input host_valid, output host_ready);
endinterface

// File: rtl/neuron_config_loader.sv
// Buffers one neuron record at a time from the host and replays it on the
// top_neurons ins bus with fixed field hold timing, then streams annealing mu words.
module neuron_config_loader #(
   parameter int                       FP_DATA_WIDTH     = 16,
   parameter int                       NUM_NEURON        = 256,
   parameter int                       NUM_ACTIVE_NEURON = 10,
   parameter int                       FIELD_HOLD        = 2,
   parameter int                       GAP_CYCLES        = 2,
   parameter int                       MU_HOLD           = 5,
   parameter logic [FP_DATA_WIDTH-1:0] SYNC_WORD         = {FP_DATA_WIDTH{1'b1}}
) (
   input  logic                            clk,
   input  logic                            reset_l,
   neuron_config_loader_if.slave           host,
   input  logic                            cfg_restart,
   output logic [FP_DATA_WIDTH-1:0]        ins,
   output logic                            load_busy,
   output logic                            load_done,
   output logic                            cfg_err,
   output logic [$clog2(NUM_NEURON)-1:0]   neuron_cnt
);

   localparam int REC_WORDS = 3 + NUM_ACTIVE_NEURON;
   localparam int PTR_W     = $clog2(REC_WORDS);
   localparam int CNT_W     = $clog2(NUM_NEURON) + 1;
   localparam int HOLD_A    = (FIELD_HOLD > MU_HOLD) ? FIELD_HOLD : MU_HOLD;
   localparam int HOLD_MAX  = (HOLD_A > NUM_ACTIVE_NEURON + GAP_CYCLES) ?
                              HOLD_A : NUM_ACTIVE_NEURON + GAP_CYCLES;
   localparam int HOLD_W    = $clog2(HOLD_MAX + 1);
   localparam logic [PTR_W-1:0] LAST_FLD = PTR_W'(REC_WORDS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_SYNC,
      ST_CAPTURE,
      ST_EMIT,
      ST_MU_STREAM
   } state_t;

   state_t                   state_reg;
   logic [FP_DATA_WIDTH-1:0] ins_reg;
   logic                     ready_reg;
   logic                     busy_reg;
   logic                     done_reg;
   logic                     err_reg;
   logic [CNT_W-2:0]         cnt_reg;
   logic [CNT_W-1:0]         n_reg;
   logic [PTR_W-1:0]         wptr_reg;
   logic [PTR_W-1:0]         fld_reg;
   logic [HOLD_W-1:0]        hold_reg;

   logic [FP_DATA_WIDTH-1:0] rec_buf [REC_WORDS];

   logic             handshake;
   logic             buf_we;
   logic [PTR_W-1:0] fld_next;
   logic [CNT_W-1:0] cnt_next;

   assign handshake = host.host_valid & ready_reg;
   assign buf_we    = (state_reg == ST_CAPTURE) && handshake && !cfg_restart;
   assign fld_next  = fld_reg + PTR_W'(1);
   assign cnt_next  = {1'b0, cnt_reg} + CNT_W'(1);

   // Remaining cycles after the first for field f: header fields hold
   // FIELD_HOLD, Q words one cycle, and the last Q word carries the gap.
   function automatic logic [HOLD_W-1:0] hold_extra(input logic [PTR_W-1:0] f);
      if (f < PTR_W'(3))
         return HOLD_W'(FIELD_HOLD - 1);
      else if (f == LAST_FLD)
         return HOLD_W'(GAP_CYCLES);
      else
         return '0;
   endfunction

   always_ff @(posedge clk) begin
      if (buf_we)
         rec_buf[wptr_reg] <= host.host_data;
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_reg <= ST_IDLE;
         ins_reg   <= '0;
         ready_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
         cnt_reg   <= '0;
         n_reg     <= '0;
         wptr_reg  <= '0;
         fld_reg   <= '0;
         hold_reg  <= '0;
      end else begin
         done_reg <= 1'b0;
         if (cfg_restart) begin
            state_reg <= ST_IDLE;
            ins_reg   <= '0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            wptr_reg  <= '0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  ready_reg <= 1'b1;
                  if (handshake) begin
                     // Full-width compare also rejects any stray upper bits.
                     if (host.host_data > FP_DATA_WIDTH'(NUM_NEURON)) begin
                        err_reg <= 1'b1;
                     end else begin
                        ins_reg   <= host.host_data;
                        n_reg     <= host.host_data[CNT_W-1:0];
                        state_reg <= ST_HDR_SYNC;
                     end
                  end
               end

               ST_HDR_SYNC: begin
                  if (handshake) begin
                     if (host.host_data != SYNC_WORD) begin
                        err_reg   <= 1'b1;
                        ins_reg   <= '0;
                        state_reg <= ST_IDLE;
                     end else begin
                        ins_reg  <= SYNC_WORD;
                        wptr_reg <= '0;
                        cnt_reg  <= '0;
                        if (n_reg != '0) begin
                           busy_reg  <= 1'b1;
                           state_reg <= ST_CAPTURE;
                        end else begin
                           done_reg  <= 1'b1;
                           state_reg <= ST_MU_STREAM;
                        end
                     end
                  end
               end

               ST_CAPTURE: begin
                  if (handshake) begin
                     if (wptr_reg == LAST_FLD) begin
                        // Vmem (slot 0) is already stored, so playback starts
                        // on the very first EMIT cycle.
                        wptr_reg  <= '0;
                        ready_reg <= 1'b0;
                        fld_reg   <= '0;
                        hold_reg  <= hold_extra('0);
                        ins_reg   <= rec_buf[0];
                        state_reg <= ST_EMIT;
                     end else begin
                        wptr_reg <= wptr_reg + PTR_W'(1);
                     end
                  end
               end

               ST_EMIT: begin
                  if (hold_reg != '0) begin
                     hold_reg <= hold_reg - HOLD_W'(1);
                  end else if (fld_reg != LAST_FLD) begin
                     fld_reg  <= fld_next;
                     ins_reg  <= rec_buf[fld_next];
                     hold_reg <= hold_extra(fld_next);
                  end else begin
                     cnt_reg   <= cnt_next[CNT_W-2:0];
                     ready_reg <= 1'b1;
                     if (cnt_next == n_reg) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_MU_STREAM;
                     end else begin
                        state_reg <= ST_CAPTURE;
                     end
                  end
               end

               ST_MU_STREAM: begin
                  // ready reopens on the last cycle a word is held, so the next
                  // accepted word lands exactly MU_HOLD cycles after the previous.
                  if (handshake) begin
                     ins_reg   <= host.host_data;
                     ready_reg <= 1'b0;
                     hold_reg  <= HOLD_W'(MU_HOLD - 2);
                  end else if (!ready_reg) begin
                     if (hold_reg == '0)
                        ready_reg <= 1'b1;
                     else
                        hold_reg <= hold_reg - HOLD_W'(1);
                  end
               end

               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   assign host.host_ready = ready_reg;
   assign ins             = ins_reg;
   assign load_busy       = busy_reg;
   assign load_done       = done_reg;
   assign cfg_err         = err_reg;
   assign neuron_cnt      = cnt_reg;

endmodule

// File: tb/tb_neuron_config_loader.sv
// Directed bench for neuron_config_loader: header handling, record playback
// timing, host stalls, mu streaming, restart and error paths.
module tb_neuron_config_loader;

   logic        clk = 1'b0;
   logic        reset_l = 1'b0;
   logic        cfg_restart = 1'b0;
   logic [15:0] ins;
   logic        load_busy;
   logic        load_done;
   logic        cfg_err;
   logic [7:0]  neuron_cnt;

   int checks = 0;
   int errors = 0;

   // Buffer slot shown on ins in each of the 18 EMIT cycles.
   int emit_idx [18] = '{0, 0, 1, 1, 2, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 12, 12};

   neuron_config_loader_if #(.FP_DATA_WIDTH(16)) bus ();

   neuron_config_loader dut (
      .clk         (clk),
      .reset_l     (reset_l),
      .host        (bus),
      .cfg_restart (cfg_restart),
      .ins         (ins),
      .load_busy   (load_busy),
      .load_done   (load_done),
      .cfg_err     (cfg_err),
      .neuron_cnt  (neuron_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge following the handshake.
   task automatic send(input logic [15:0] w);
      int n;
      n = 0;
      bus.host_data  = w;
      bus.host_valid = 1'b1;
      while (!bus.host_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50)
         check("send_ready", 16'(bus.host_ready), 16'd1);
      tick();
      bus.host_valid = 1'b0;
      $display("host word %h accepted, ins=%h cnt=%0d", w, ins, neuron_cnt);
   endtask

   task automatic send_rec(input logic [15:0] base, input bit stall, input logic [15:0] held);
      for (int w = 0; w < 13; w++) begin
         send(base + 16'(w));
         if (w < 12) begin
            check("capture_hold", ins, held);
            if (stall && (w == 0 || w == 6)) begin
               repeat (2) tick();
               check("stall_hold", ins, held);
               check("stall_ready", 16'(bus.host_ready), 16'd1);
            end
         end
      end
   endtask

   task automatic emit_check(input logic [15:0] base);
      for (int c = 0; c < 18; c++) begin
         check("emit_ins", ins, base + 16'(emit_idx[c]));
         check("emit_ready", 16'(bus.host_ready), 16'd0);
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.host_valid = 1'b0;
      bus.host_data  = '0;
      repeat (2) tick();

      check("rst_ins", ins, 16'h0000);
      check("rst_ready", 16'(bus.host_ready), 16'd0);
      check("rst_busy", 16'(load_busy), 16'd0);
      check("rst_done", 16'(load_done), 16'd0);
      check("rst_err", 16'(cfg_err), 16'd0);
      check("rst_cnt", 16'(neuron_cnt), 16'd0);
      reset_l = 1'b1;
      tick();
      check("idle_ready", 16'(bus.host_ready), 16'd1);

      // Oversize header
      send(16'h0101);
      check("over_err", 16'(cfg_err), 16'd1);
      check("over_ins", ins, 16'h0000);
      check("over_ready", 16'(bus.host_ready), 16'd1);
      repeat (2) tick();
      check("over_ins_quiet", ins, 16'h0000);
      cfg_restart = 1'b1;
      tick();
      cfg_restart = 1'b0;
      check("restart_clr_err", 16'(cfg_err), 16'd0);

      // Bad sync word
      send(16'h0003);
      check("bad_hdr_ins", ins, 16'h0003);
      send(16'hFFF0);
      check("bad_sync_err", 16'(cfg_err), 16'd1);
      check("bad_sync_ins", ins, 16'h0000);
      check("bad_sync_ready", 16'(bus.host_ready), 16'd1);
      check("bad_sync_busy", 16'(load_busy), 16'd0);

      // Nominal two-neuron load, second record with host stalls
      send(16'h0002);
      check("hdr_count", ins, 16'h0002);
      send(16'hFFFF);
      check("hdr_sync", ins, 16'hFFFF);
      check("hdr_busy", 16'(load_busy), 16'd1);
      send_rec(16'h1000, 1'b0, 16'hFFFF);
      emit_check(16'h1000);
      check("n1_cnt", 16'(neuron_cnt), 16'd1);
      check("n1_done", 16'(load_done), 16'd0);
      check("n1_ready", 16'(bus.host_ready), 16'd1);
      check("n1_ins_hold", ins, 16'h100C);
      send_rec(16'h2000, 1'b1, 16'h100C);
      emit_check(16'h2000);
      check("n2_cnt", 16'(neuron_cnt), 16'd2);
      check("n2_done", 16'(load_done), 16'd1);
      check("n2_busy", 16'(load_busy), 16'd0);
      check("n2_err_sticky", 16'(cfg_err), 16'd1);
      tick();
      check("done_pulse_end", 16'(load_done), 16'd0);

      // Mu stream: two back-to-back words, then an empty window
      check("mu_ready0", 16'(bus.host_ready), 16'd1);
      bus.host_valid = 1'b1;
      bus.host_data  = 16'h4100;
      tick();
      bus.host_data = 16'h4200;
      for (int k = 0; k < 5; k++) begin
         check("mu1_ins", ins, 16'h4100);
         check("mu1_ready", 16'(bus.host_ready), (k == 4) ? 16'd1 : 16'd0);
         tick();
      end
      bus.host_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("mu2_ins", ins, 16'h4200);
         check("mu2_ready", 16'(bus.host_ready), (k == 4) ? 16'd1 : 16'd0);
         tick();
      end
      repeat (3) tick();
      check("mu_idle_ins", ins, 16'h4200);
      check("mu_idle_ready", 16'(bus.host_ready), 16'd1);
      $display("mu stream 4100/4200 done");

      // Restart with a coincident handshake, which must be discarded
      cfg_restart    = 1'b1;
      bus.host_valid = 1'b1;
      bus.host_data  = 16'h0005;
      tick();
      cfg_restart    = 1'b0;
      bus.host_valid = 1'b0;
      check("rs_ins", ins, 16'h0000);
      check("rs_err", 16'(cfg_err), 16'd0);
      check("rs_cnt", 16'(neuron_cnt), 16'd0);
      tick();
      check("rs_discard", ins, 16'h0000);

      // Restart on the 7th EMIT cycle of the second neuron
      send(16'h0002);
      send(16'hFFFF);
      send_rec(16'h3000, 1'b0, 16'hFFFF);
      emit_check(16'h3000);
      send_rec(16'h4000, 1'b0, 16'h300C);
      repeat (6) tick();
      check("mid_emit_ins", ins, 16'h4003);
      check("mid_emit_cnt", 16'(neuron_cnt), 16'd1);
      cfg_restart = 1'b1;
      tick();
      cfg_restart = 1'b0;
      check("mid_rs_ins", ins, 16'h0000);
      check("mid_rs_cnt", 16'(neuron_cnt), 16'd0);
      check("mid_rs_ready", 16'(bus.host_ready), 16'd1);
      check("mid_rs_busy", 16'(load_busy), 16'd0);
      $display("restart mid-emit done");

      // Zero-neuron header goes straight to mu streaming
      send(16'h0000);
      send(16'hFFFF);
      check("n0_done", 16'(load_done), 16'd1);
      check("n0_busy", 16'(load_busy), 16'd0);
      check("n0_ins", ins, 16'hFFFF);
      check("n0_ready", 16'(bus.host_ready), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
